// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// Holds the FSM encoding, the buffered {pc, instr} entry and reset-time defaults.
package fetch_pkg;

  localparam int          INSTR_W             = 32;
  localparam int          DEF_MAX_OUTSTANDING = 2;
  localparam logic [31:0] DEF_RESET_PC        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus: imem request/response, decode handoff and redirect input.
// master = the fetch unit, slave = memory/decode/branch environment.
interface pc_fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [31:0]        imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [31:0]        dec_pc;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO; push visible at the head one cycle later.
// No internal backpressure: the caller's credit scheme keeps pushes off a full buffer.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_dat,
  output logic [1:0]   count,
  output logic         valid
);

  fetch_entry_t r_mem [2];
  logic         r_wptr, r_rptr;
  logic [1:0]   r_count;
  logic         w_push, w_pop;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign head_dat = r_mem[r_rptr];
  assign count    = r_count;
  assign valid    = (r_count != 2'd0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Sequential instruction fetcher with redirect, stale-response discard and misaligned-target fault.
// Rsp-to-decode latency 1 cycle; requests stall while in-flight + buffered reaches MAX_OUTSTANDING.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEF_RESET_PC,
  parameter int          MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input logic             clock,
  input logic             reset_n,
  pc_fetch_unit_if.master bus
);

  localparam logic [2:0] LP_MAX_OCC = 3'(MAX_OUTSTANDING);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc, r_rsp_pc;
  logic [1:0]   r_outstanding, r_discard;
  logic [1:0]   w_outstanding_nxt, w_discard_nxt;
  logic [1:0]   w_buf_count;
  logic         w_buf_valid;
  fetch_entry_t w_head, w_push_dat;
  logic [2:0]   w_occ;
  logic         w_req_valid, w_redir_ok, w_redir_bad, w_req_fire;
  logic         w_rsp_drop, w_push, w_pop, w_flush;

  assign w_occ = {1'b0, r_outstanding} + {1'b0, w_buf_count};

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_BOOT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_redir_ok  = 1'b0;
    w_redir_bad = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_req_valid = (w_occ < LP_MAX_OCC) && !bus.redirect_valid;
        if (bus.redirect_valid) begin
          if (bus.redirect_pc[1:0] != 2'b00) begin
            w_redir_bad = 1'b1;
            w_state_nxt = ST_FAULT;
          end else begin
            w_redir_ok = 1'b1;
          end
        end
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  assign w_req_fire = w_req_valid && bus.imem_req_ready;
  assign w_flush    = w_redir_ok || w_redir_bad;
  assign w_rsp_drop = w_flush || (r_discard != 2'd0) || (r_state != ST_RUN);
  assign w_push     = bus.imem_rsp_valid && !w_rsp_drop;
  assign w_pop      = w_buf_valid && bus.dec_ready;

  assign w_outstanding_nxt = r_outstanding + {1'b0, w_req_fire} - {1'b0, bus.imem_rsp_valid};

  // Every request still in flight after a redirect belongs to the old path.
  always_comb begin
    w_discard_nxt = r_discard;
    if (w_redir_ok)                                    w_discard_nxt = w_outstanding_nxt;
    else if (bus.imem_rsp_valid && r_discard != 2'd0)  w_discard_nxt = r_discard - 2'd1;
  end

  // Kept responses come back in request order, so their pc is a running +4 from the last target.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= 2'd0;
      r_discard     <= 2'd0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      if (w_redir_ok) begin
        r_fetch_pc <= bus.redirect_pc;
        r_rsp_pc   <= bus.redirect_pc;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
      end
    end
  end

  assign w_push_dat = '{pc: r_rsp_pc, instr: bus.imem_rsp_data};

  fetch_buffer u_buf (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (w_push),
    .push_dat (w_push_dat),
    .pop      (w_pop),
    .flush    (w_flush),
    .head_dat (w_head),
    .count    (w_buf_count),
    .valid    (w_buf_valid)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.dec_valid      = w_buf_valid;
  assign bus.dec_instr      = w_head.instr;
  assign bus.dec_pc         = w_head.pc;
  assign bus.fetch_fault    = (r_state == ST_FAULT);

endmodule
